// File: rtl/wb_stream_ring_sched.sv
// -----------------------------------------------------------------------------
// wb_stream_ring_sched
//
// Wishbone-configured ring sequencer for a stream writer. The CPU programs a
// ring of NBUF buffer base addresses plus a common buffer size and burst size.
// Once run is set, the block launches the writer on buffer 0, waits for the
// transfer to finish (falling edge of busy), and relaunches on the next buffer.
// This continues until the last buffer (loop=0), or until the CPU clears run
// (loop=1). Each completed buffer bumps done_cnt and optionally raises irq.
//
// Ports
//   wb_clk_i, wb_rst_i        clock, asynchronous active-high reset
//   wb_adr_i .. wb_bte_i      Wishbone slave inputs (sel/cti/bte ignored)
//   wb_dat_o, wb_ack_o        read data (combinational), registered ack
//   wb_err_o                  always 0
//   irq                       buffer-done interrupt, level, W1C in STATUS
//   busy                      writer busy input
//   enable                    one-cycle launch pulse to the writer
//   start_adr, buf_size,
//   burst_size                launch parameters, change only on a launch load
//
// Register map (index = wb_adr_i[5:2])
//   0 CTRL       bit0 run, bit1 loop, bit2 irq_en
//   1 STATUS     bit0 active, bit1 irq (W1C), [6:4] cur_idx, [31:16] done_cnt
//   2 BUF_SIZE   3 BURST_SIZE   4..4+NBUF-1 BUF_ADR[i]   others read 0
// -----------------------------------------------------------------------------
module wb_stream_ring_sched #(
   parameter int WB_AW = 32,
   parameter int WB_DW = 32,
   parameter int NBUF  = 4
) (
   input  logic               wb_clk_i,
   input  logic               wb_rst_i,
   input  logic [5:0]         wb_adr_i,
   input  logic [WB_DW-1:0]   wb_dat_i,
   input  logic [WB_DW/8-1:0] wb_sel_i,
   input  logic               wb_we_i,
   input  logic               wb_cyc_i,
   input  logic               wb_stb_i,
   input  logic [2:0]         wb_cti_i,
   input  logic [1:0]         wb_bte_i,
   output logic [WB_DW-1:0]   wb_dat_o,
   output logic               wb_ack_o,
   output logic               wb_err_o,
   output logic               irq,
   input  logic               busy,
   output logic               enable,
   output logic [WB_AW-1:0]   start_adr,
   output logic [WB_AW-1:0]   buf_size,
   output logic [WB_AW-1:0]   burst_size
);

   localparam int IW = (NBUF > 1) ? $clog2(NBUF) : 1;
   localparam logic [3:0] ADR_FIRST = 4'd4;
   localparam logic [3:0] ADR_LAST  = 4'(4 + NBUF - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_LAUNCH    = 3'd1,
      S_WAIT_BUSY = 3'd2,
      S_RUN       = 3'd3,
      S_DONE      = 3'd4
   } state_t;

   state_t           state_q;
   logic             ack_q;
   logic             run_q, loop_q, irq_en_q, irq_q;
   logic [15:0]      done_cnt_q;
   logic [IW-1:0]    cur_idx_q;
   logic             busy_q;
   logic             enable_q;
   logic [WB_AW-1:0] start_adr_q, buf_size_o_q, burst_size_o_q;
   logic [WB_AW-1:0] buf_size_q, burst_size_q;
   logic [WB_AW-1:0] buf_adr_q [NBUF];

   logic [3:0]       reg_idx_s;
   logic             wr_s, wr_ctrl_s, wr_status_s, wr_bsize_s, wr_burst_s, wr_adr_s;
   logic             adr_hit_s;
   logic [IW-1:0]    adr_sel_s;
   logic [IW-1:0]    nxt_idx_s;
   logic             active_s;
   logic [WB_DW-1:0] rd_data_s;
   logic             unused_s;

   assign reg_idx_s = wb_adr_i[5:2];
   // A write commits on the edge that closes the ack cycle.
   assign wr_s      = wb_cyc_i & wb_stb_i & wb_we_i & ack_q;
   assign adr_hit_s = (reg_idx_s >= ADR_FIRST) && (reg_idx_s <= ADR_LAST);
   assign adr_sel_s = IW'(reg_idx_s - ADR_FIRST);
   assign nxt_idx_s = cur_idx_q + IW'(1);
   assign active_s  = (state_q != S_IDLE);
   assign unused_s  = ^{wb_sel_i, wb_cti_i, wb_bte_i, wb_adr_i[1:0]};

   // Write-strobe decode per register.
   always_comb begin
      wr_ctrl_s   = 1'b0;
      wr_status_s = 1'b0;
      wr_bsize_s  = 1'b0;
      wr_burst_s  = 1'b0;
      wr_adr_s    = 1'b0;
      case (reg_idx_s)
         4'd0:    wr_ctrl_s   = wr_s;
         4'd1:    wr_status_s = wr_s;
         4'd2:    wr_bsize_s  = wr_s;
         4'd3:    wr_burst_s  = wr_s;
         default: wr_adr_s    = wr_s & adr_hit_s;
      endcase
   end

   // Combinational read mux.
   always_comb begin
      rd_data_s = '0;
      case (reg_idx_s)
         4'd0:    rd_data_s = WB_DW'({irq_en_q, loop_q, run_q});
         4'd1:    rd_data_s = WB_DW'({done_cnt_q, 9'd0, 3'(cur_idx_q), 2'd0, irq_q, active_s});
         4'd2:    rd_data_s = WB_DW'(buf_size_q);
         4'd3:    rd_data_s = WB_DW'(burst_size_q);
         default: begin
            if (adr_hit_s) begin
               rd_data_s = WB_DW'(buf_adr_q[adr_sel_s]);
            end else begin
               rd_data_s = '0;
            end
         end
      endcase
   end

   // Ack generator: one-cycle pulse, then one idle cycle even under held stb.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         ack_q <= 1'b0;
      end else begin
         ack_q <= wb_cyc_i & wb_stb_i & ~ack_q;
      end
   end

   // Configuration registers; they feed the outputs only at a launch load.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         buf_size_q   <= '0;
         burst_size_q <= '0;
         for (int i = 0; i < NBUF; i++) begin
            buf_adr_q[i] <= '0;
         end
      end else begin
         if (wr_bsize_s) buf_size_q   <= wb_dat_i[WB_AW-1:0];
         if (wr_burst_s) burst_size_q <= wb_dat_i[WB_AW-1:0];
         if (wr_adr_s)   buf_adr_q[adr_sel_s] <= wb_dat_i[WB_AW-1:0];
      end
   end

   // Sequencer FSM with CTRL, irq, counters and registered launch outputs.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q        <= S_IDLE;
         run_q          <= 1'b0;
         loop_q         <= 1'b0;
         irq_en_q       <= 1'b0;
         irq_q          <= 1'b0;
         done_cnt_q     <= 16'd0;
         cur_idx_q      <= '0;
         busy_q         <= 1'b0;
         enable_q       <= 1'b0;
         start_adr_q    <= '0;
         buf_size_o_q   <= '0;
         burst_size_o_q <= '0;
      end else begin
         busy_q   <= busy;
         enable_q <= 1'b0;
         if (wr_ctrl_s) begin
            run_q    <= wb_dat_i[0];
            loop_q   <= wb_dat_i[1];
            irq_en_q <= wb_dat_i[2];
         end
         // W1C first so a same-edge set in DONE below takes priority.
         if (wr_status_s && wb_dat_i[1]) irq_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (run_q) begin
                  cur_idx_q      <= '0;
                  start_adr_q    <= buf_adr_q[0];
                  buf_size_o_q   <= buf_size_q;
                  burst_size_o_q <= burst_size_q;
                  enable_q       <= 1'b1;
                  state_q        <= S_LAUNCH;
               end
            end
            S_LAUNCH: state_q <= S_WAIT_BUSY;
            S_WAIT_BUSY: begin
               if (busy) state_q <= S_RUN;
            end
            S_RUN: begin
               if (busy_q && !busy) state_q <= S_DONE;
            end
            S_DONE: begin
               done_cnt_q <= done_cnt_q + 16'd1;
               if (irq_en_q) irq_q <= 1'b1;
               if (!run_q) begin
                  state_q <= S_IDLE;
               end else if (!loop_q && (cur_idx_q == IW'(NBUF - 1))) begin
                  run_q   <= 1'b0;
                  state_q <= S_IDLE;
               end else begin
                  cur_idx_q      <= nxt_idx_s;
                  start_adr_q    <= buf_adr_q[nxt_idx_s];
                  buf_size_o_q   <= buf_size_q;
                  burst_size_o_q <= burst_size_q;
                  enable_q       <= 1'b1;
                  state_q        <= S_LAUNCH;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign wb_dat_o   = rd_data_s;
   assign wb_ack_o   = ack_q;
   assign wb_err_o   = 1'b0;
   assign irq        = irq_q;
   assign enable     = enable_q;
   assign start_adr  = start_adr_q;
   assign buf_size   = buf_size_o_q;
   assign burst_size = burst_size_o_q;

endmodule

// File: tb/tb_wb_stream_ring_sched.sv
// -----------------------------------------------------------------------------
// Testbench for wb_stream_ring_sched (NBUF=4). A writer model holds busy for
// ten cycles after each enable and logs the launch parameters it was given.
// -----------------------------------------------------------------------------
module tb_wb_stream_ring_sched;

   logic        clk, rst;
   logic [5:0]  adr;
   logic [31:0] dat_w;
   logic [3:0]  sel;
   logic        we, cyc, stb;
   logic [2:0]  cti;
   logic [1:0]  bte;
   logic [31:0] dat_r;
   logic        ack, err, irq_w;
   logic        busy, model_busy, man_busy, model_on;
   logic        enable;
   logic [31:0] start_adr, buf_size, burst_size;

   int          checks   = 0;
   int          failures = 0;
   int          n_en;
   logic [31:0] en_adr  [16];
   logic [31:0] en_size [16];
   logic        prev_en;

   typedef struct {
      logic        we;
      logic [3:0]  idx;
      logic [31:0] dat;
      logic [31:0] exp;
   } vec_t;

   vec_t        vecs [17];
   logic [31:0] exp_seq [6];

   assign busy = model_busy | man_busy;

   wb_stream_ring_sched #(.WB_AW(32), .WB_DW(32), .NBUF(4)) dut (
      .wb_clk_i   (clk),
      .wb_rst_i   (rst),
      .wb_adr_i   (adr),
      .wb_dat_i   (dat_w),
      .wb_sel_i   (sel),
      .wb_we_i    (we),
      .wb_cyc_i   (cyc),
      .wb_stb_i   (stb),
      .wb_cti_i   (cti),
      .wb_bte_i   (bte),
      .wb_dat_o   (dat_r),
      .wb_ack_o   (ack),
      .wb_err_o   (err),
      .irq        (irq_w),
      .busy       (busy),
      .enable     (enable),
      .start_adr  (start_adr),
      .buf_size   (buf_size),
      .burst_size (burst_size)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      failures++;
      $display("FAIL %s: wait bound expired", name);
   endtask

   task automatic wb_cycle(input logic w, input logic [3:0] idx, input logic [31:0] d,
                           output logic [31:0] q);
      int n;
      @(negedge clk);
      adr = {idx, 2'b00}; dat_w = d; we = w; cyc = 1'b1; stb = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (ack !== 1'b1 && n < 20);
      if (ack !== 1'b1) timeout("wb_ack");
      q = dat_r;
      @(posedge clk);
      #1;
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
   endtask

   task automatic wb_write(input logic [3:0] idx, input logic [31:0] d);
      logic [31:0] dummy;
      wb_cycle(1'b1, idx, d, dummy);
   endtask

   task automatic wb_read(input logic [3:0] idx, output logic [31:0] q);
      wb_cycle(1'b0, idx, 32'h0, q);
   endtask

   task automatic wait_idle(input string name);
      logic [31:0] s;
      int n;
      n = 0;
      do begin
         wb_read(4'd1, s);
         n++;
      end while (s[0] && n < 100);
      if (s[0]) timeout(name);
   endtask

   task automatic wait_enable(input string name);
      int n;
      n = 0;
      while (enable !== 1'b1 && n < 30) begin
         @(negedge clk);
         n++;
      end
      if (enable !== 1'b1) timeout(name);
   endtask

   task automatic program_cfg();
      wb_write(4'd2, 32'h400);
      wb_write(4'd3, 32'h40);
      for (int k = 0; k < 4; k++) wb_write(4'(4 + k), 32'h1000 * (k + 1));
   endtask

   // Writer model: logs each launch, holds busy for ten cycles when enabled.
   initial begin
      int left;
      left = 0; model_busy = 1'b0; n_en = 0; prev_en = 1'b0;
      forever begin
         @(negedge clk);
         if (enable === 1'b1) begin
            checks++;
            if (prev_en) begin
               failures++;
               $display("FAIL enable_consecutive: got 1 after 1 expected 0");
            end
            if (n_en < 16) begin
               en_adr[n_en]  = start_adr;
               en_size[n_en] = buf_size;
            end
            n_en++;
            if (model_on) begin
               model_busy = 1'b1;
               left = 10;
            end
         end else if (left > 0) begin
            left--;
            if (left == 0) model_busy = 1'b0;
         end
         prev_en = enable;
      end
   end

   initial begin
      logic [31:0] q;
      int base;
      int n;
      rst = 1'b1; adr = 6'd0; dat_w = 32'h0; sel = 4'hF; we = 1'b0;
      cyc = 1'b0; stb = 1'b0; cti = 3'd0; bte = 2'd0;
      man_busy = 1'b0; model_on = 1'b1;

      vecs[0]  = '{1'b1, 4'd2,  32'h0000_0400, 32'h0};
      vecs[1]  = '{1'b1, 4'd3,  32'h0000_0040, 32'h0};
      vecs[2]  = '{1'b1, 4'd4,  32'h0000_1000, 32'h0};
      vecs[3]  = '{1'b1, 4'd5,  32'h0000_2000, 32'h0};
      vecs[4]  = '{1'b1, 4'd6,  32'h0000_3000, 32'h0};
      vecs[5]  = '{1'b1, 4'd7,  32'h0000_4000, 32'h0};
      vecs[6]  = '{1'b1, 4'd15, 32'hDEAD_BEEF, 32'h0};
      vecs[7]  = '{1'b1, 4'd0,  32'h0000_0006, 32'h0};
      vecs[8]  = '{1'b0, 4'd0,  32'h0,         32'h0000_0006};
      vecs[9]  = '{1'b1, 4'd0,  32'h0000_0000, 32'h0};
      vecs[10] = '{1'b0, 4'd2,  32'h0,         32'h0000_0400};
      vecs[11] = '{1'b0, 4'd3,  32'h0,         32'h0000_0040};
      vecs[12] = '{1'b0, 4'd4,  32'h0,         32'h0000_1000};
      vecs[13] = '{1'b0, 4'd7,  32'h0,         32'h0000_4000};
      vecs[14] = '{1'b0, 4'd8,  32'h0,         32'h0000_0000};
      vecs[15] = '{1'b0, 4'd15, 32'h0,         32'h0000_0000};
      vecs[16] = '{1'b0, 4'd1,  32'h0,         32'h0000_0000};
      exp_seq = '{32'h1000, 32'h2000, 32'h3000, 32'h4000, 32'h1000, 32'h2000};

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_enable", {31'd0, enable}, 32'h0);
      chk("rst_start_adr", start_adr, 32'h0);
      chk("rst_buf_size", buf_size, 32'h0);
      chk("rst_burst_size", burst_size, 32'h0);
      chk("rst_irq", {31'd0, irq_w}, 32'h0);
      chk("rst_ack", {31'd0, ack}, 32'h0);
      chk("rst_err", {31'd0, err}, 32'h0);
      rst = 1'b0;
      wb_read(4'd1, q);
      chk("rst_status", q, 32'h0);

      // Register access table
      for (int i = 0; i < 17; i++) begin
         if (vecs[i].we) begin
            wb_write(vecs[i].idx, vecs[i].dat);
         end else begin
            wb_read(vecs[i].idx, q);
            chk($sformatf("vec%0d_idx%0d", i, vecs[i].idx), q, vecs[i].exp);
         end
      end

      // Single pass with launch latency and shadowed BUF_SIZE
      base = n_en;
      wb_write(4'd0, 32'h5);
      @(negedge clk);
      chk("launch_T1_enable", {31'd0, enable}, 32'h0);
      @(negedge clk);
      chk("launch_T2_enable", {31'd0, enable}, 32'h1);
      chk("launch_T2_start_adr", start_adr, 32'h1000);
      chk("launch_T2_buf_size", buf_size, 32'h400);
      chk("launch_T2_burst_size", burst_size, 32'h40);
      wb_write(4'd2, 32'h800);
      @(negedge clk);
      chk("shadow_buf_size", buf_size, 32'h400);
      wait_idle("single_idle");
      chk("single_count", n_en - base, 32'd4);
      for (int k = 0; k < 4; k++) chk($sformatf("single_adr%0d", k), en_adr[base + k], exp_seq[k]);
      chk("shadow_size0", en_size[base], 32'h400);
      chk("shadow_size1", en_size[base + 1], 32'h800);
      wb_read(4'd1, q);
      chk("single_status", q, 32'h0004_0032);
      wb_read(4'd0, q);
      chk("single_ctrl", q, 32'h4);
      chk("single_irq", {31'd0, irq_w}, 32'h1);

      // W1C clears irq
      wb_write(4'd1, 32'h2);
      @(negedge clk);
      chk("w1c_irq", {31'd0, irq_w}, 32'h0);
      wb_read(4'd1, q);
      chk("w1c_status", q, 32'h0004_0030);

      // Asynchronous reset mid-transfer
      base = n_en;
      wb_write(4'd0, 32'h1);
      wait_enable("mid_rst_enable");
      repeat (3) @(negedge clk);
      chk("pre_rst_start_adr", start_adr, 32'h1000);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_start_adr", start_adr, 32'h0);
      chk("mid_rst_buf_size", buf_size, 32'h0);
      chk("mid_rst_burst_size", burst_size, 32'h0);
      chk("mid_rst_enable", {31'd0, enable}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      repeat (12) @(negedge clk);
      wb_read(4'd1, q);
      chk("post_rst_status", q, 32'h0);
      wb_read(4'd2, q);
      chk("post_rst_buf_size_reg", q, 32'h0);
      chk("post_rst_no_launch", n_en - base, 32'd1);

      // Loop wrap over six buffers, then stop with run=0
      program_cfg();
      base = n_en;
      wb_write(4'd0, 32'h7);
      n = 0;
      while (n_en < base + 6 && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (n_en < base + 6) timeout("loop_six");
      wb_write(4'd0, 32'h6);
      wait_idle("loop_idle");
      chk("loop_count", n_en - base, 32'd6);
      for (int k = 0; k < 6; k++) chk($sformatf("loop_adr%0d", k), en_adr[base + k], exp_seq[k]);
      wb_read(4'd1, q);
      chk("loop_status", q, 32'h0006_0012);

      // IRQ set/clear race on the DONE edge, then irq_en=0
      wb_write(4'd1, 32'h2);
      @(negedge clk);
      chk("race_pre_irq", {31'd0, irq_w}, 32'h0);
      model_on = 1'b0;
      wb_write(4'd0, 32'h5);
      wait_enable("race_enable");
      man_busy = 1'b1;
      repeat (3) @(negedge clk);
      man_busy = 1'b0;
      adr = {4'd1, 2'b00}; dat_w = 32'h2; we = 1'b1; cyc = 1'b1; stb = 1'b1;
      @(negedge clk);
      chk("race_ack", {31'd0, ack}, 32'h1);
      @(posedge clk);
      #1;
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      @(negedge clk);
      chk("race_irq_set_wins", {31'd0, irq_w}, 32'h1);
      chk("race_next_enable", {31'd0, enable}, 32'h1);
      chk("race_next_start_adr", start_adr, 32'h2000);
      wb_write(4'd1, 32'h2);
      @(negedge clk);
      chk("race_later_w1c", {31'd0, irq_w}, 32'h0);
      wb_write(4'd0, 32'h0);
      @(negedge clk);
      man_busy = 1'b1;
      repeat (2) @(negedge clk);
      man_busy = 1'b0;
      repeat (3) @(negedge clk);
      chk("irq_en0_irq", {31'd0, irq_w}, 32'h0);
      wb_read(4'd1, q);
      chk("irq_en0_status", q, 32'h0008_0010);

      // Held cyc/stb: ack toggles 0,1,0,1; unmapped index reads 0
      @(negedge clk);
      adr = {4'd15, 2'b00}; we = 1'b0; cyc = 1'b1; stb = 1'b1;
      for (int k = 0; k < 4; k++) begin
         if (k > 0) @(negedge clk);
         #1;
         chk($sformatf("held_ack%0d", k), {31'd0, ack}, (k % 2 == 1) ? 32'h1 : 32'h0);
      end
      chk("unmapped15", dat_r, 32'h0);
      chk("err_tied", {31'd0, err}, 32'h0);
      @(negedge clk);
      cyc = 1'b0; stb = 1'b0;
      repeat (2) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
